fp_add_sequencer: RTL

- Multi-cycle controller that sequences the single-precision adder datapath: align, add, normalize, round, exponent update.
- Accepts operand-pair requests on a valid/ready handshake and drives one-hot stage enables into the datapath.
- Captures the datapath status flags: overflow, round overflow, max/min exponent, underflow.
- Returns a result-valid handshake with sticky exception flags, between the operand-issue logic and the result writeback.

---
 rtl/fp_add_pkg.sv | 24 ++
 rtl/fp_add_seq_flag_reg.sv | 41 ++++
 rtl/fp_add_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared definitions for the single-precision adder sequencer:
// FSM state encoding, exception-flag bit positions and default widths.
package fp_add_pkg;

  localparam int FLAG_W_DEF = 5;

  // Exception flag vector layout {invalid, div0, ovf, unf, inexact}
  localparam int FLG_INV = 4;
  localparam int FLG_DZ  = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_NX  = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_UPD   = 3'd5,
    S_DONE  = 3'd6
  } seq_state_t;

endpackage

// File: rtl/fp_add_seq_flag_reg.sv
// Exception flag register: cleared when a new operand pair is accepted,
// loaded from the datapath status at exponent update. An exact-zero
// result masks ovf/unf/inexact. invalid/div0 are reserved and held 0.
module fp_add_seq_flag_reg
  import fp_add_pkg::*;
#(
  parameter int FLAG_W = FLAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture,
  input  logic              dp_zero_res,
  input  logic              dp_max_exp,
  input  logic              dp_underflow,
  input  logic              dp_inexact,
  output logic [FLAG_W-1:0] flags,
  output logic              zero_res
);

  // Flag capture/clear with zero-result masking
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags    <= '0;
      zero_res <= 1'b0;
    end else if (clear) begin
      flags    <= '0;
      zero_res <= 1'b0;
    end else if (capture) begin
      flags    <= '0;
      zero_res <= dp_zero_res;
      if (!dp_zero_res) begin
        flags[FLG_OVF] <= dp_max_exp;
        flags[FLG_UNF] <= dp_underflow & dp_inexact;
        flags[FLG_NX]  <= dp_inexact | dp_max_exp;
      end
    end
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle controller for the single-precision adder datapath.
// Sequences ALIGN -> ADD -> NORM -> ROUND -> UPD -> DONE with one-hot,
// registered stage enables; round overflow may trigger up to MAX_RENORM
// extra NORM/ROUND passes. Optional feature macro: FP_ADD_SEQ_PERF_CNT_EN
// adds saturating op_count / stall_count outputs.
module fp_add_sequencer
  import fp_add_pkg::*;
#(
  parameter int FLAG_W     = FLAG_W_DEF,
  parameter int MAX_RENORM = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              en_align,
  output logic              en_add,
  output logic              en_norm,
  output logic              en_round,
  output logic              en_expupd,
  input  logic              dp_ovf_rnd,
  input  logic              dp_zero_res,
  input  logic              dp_max_exp,
  input  logic              dp_min_exp,
  input  logic              dp_underflow,
  input  logic              dp_inexact,
  output logic [FLAG_W-1:0] flags,
  output logic              zero_res,
  output logic              busy
`ifdef FP_ADD_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  stall_count
`endif
);

  localparam int RN_W = (MAX_RENORM < 1) ? 1 : $clog2(MAX_RENORM + 1);

  seq_state_t      state;
  logic [RN_W-1:0] rn_cnt;
  logic            accept;

  assign accept = (state == S_IDLE) && in_valid && in_ready;

  // Min-exponent saturation is already folded into dp_underflow upstream.
  logic unused_dp_min_exp;
  assign unused_dp_min_exp = dp_min_exp;

  // Sequencing FSM with registered handshake, busy and one-hot enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rn_cnt    <= '0;
      en_align  <= 1'b0;
      en_add    <= 1'b0;
      en_norm   <= 1'b0;
      en_round  <= 1'b0;
      en_expupd <= 1'b0;
    end else begin
      en_align  <= 1'b0;
      en_add    <= 1'b0;
      en_norm   <= 1'b0;
      en_round  <= 1'b0;
      en_expupd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            state    <= S_ALIGN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            rn_cnt   <= '0;
            en_align <= 1'b1;
          end
        end
        S_ALIGN: begin
          state  <= S_ADD;
          en_add <= 1'b1;
        end
        S_ADD: begin
          state   <= S_NORM;
          en_norm <= 1'b1;
        end
        S_NORM: begin
          state    <= S_ROUND;
          en_round <= 1'b1;
        end
        S_ROUND: begin
          if (dp_ovf_rnd && (rn_cnt < RN_W'(MAX_RENORM))) begin
            state   <= S_NORM;
            rn_cnt  <= rn_cnt + RN_W'(1);
            en_norm <= 1'b1;
          end else begin
            state     <= S_UPD;
            en_expupd <= 1'b1;
          end
        end
        S_UPD: begin
          state     <= S_DONE;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
        S_DONE: begin
          // Completing a result never restarts in the same cycle.
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  fp_add_seq_flag_reg #(.FLAG_W(FLAG_W)) u_flag_reg (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept),
    .capture      (state == S_UPD),
    .dp_zero_res  (dp_zero_res),
    .dp_max_exp   (dp_max_exp),
    .dp_underflow (dp_underflow),
    .dp_inexact   (dp_inexact),
    .flags        (flags),
    .zero_res     (zero_res)
  );

`ifdef FP_ADD_SEQ_PERF_CNT_EN
  // Saturating counters for completed results and back-pressure cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count    <= '0;
      stall_count <= '0;
    end else if (state == S_DONE) begin
      if (out_ready && (op_count != '1)) begin
        op_count <= op_count + CNT_W'(1);
      end
      if (!out_ready && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
